regfile_exec_unit: RTL

- Sequential execute/write-back stage between the instruction source and the 8x32 register file (regs32x8).
- Accepts one register-register operation, drives the register file read ports and latches operands a/b.
- Computes a 32-bit result (single-cycle ALU ops, iterative shift-add multiply) and writes it back through the file's write port.
- One operation in flight at a time; start/busy/done handshake.

---
 rtl/regfile_exec_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/regfile_exec_unit.sv
// ============================================================================
// Module   : regfile_exec_unit
// Purpose  : Execute/write-back stage for the 8x32 register file. It reads two
//            operands, runs an ALU op or an iterative multiply, and writes the
//            result back through the file's write port.
// Option   : REGFILE_EXEC_MUL_EN enables the shift-add multiply path (op=111).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module regfile_exec_unit #(
  parameter int WIDTH     = 32,
  parameter int AW        = 3,
  parameter int MUL_CNT_W = 6
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    rd,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             read_a,
  output logic [AW-1:0]    a_addr,
  output logic             read_b,
  output logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             write,
  output logic [AW-1:0]    in_addr,
  output logic [WIDTH-1:0] in
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  if (MUL_CNT_W < $clog2(WIDTH) + 1) begin : g_cnt_w_check
    $error("MUL_CNT_W too narrow for WIDTH");
  end

`ifdef REGFILE_EXEC_MUL_EN
  typedef enum logic [2:0] {IDLE, READ, EXEC, MUL, WB} state_t;
  localparam logic [MUL_CNT_W-1:0] MUL_LAST = MUL_CNT_W'(WIDTH - 1);
  logic [MUL_CNT_W-1:0] cnt;
  logic [WIDTH-1:0]     mul_sum;
`else
  typedef enum logic [2:0] {IDLE, READ, EXEC, WB} state_t;
`endif

  state_t           state;
  logic [2:0]       op_q;
  logic [AW-1:0]    rd_q;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] alu;

  always_comb begin
    alu = '0;
    case (op_q)
      OP_ADD:  alu = opa + opb;
      OP_SUB:  alu = opa - opb;
      OP_AND:  alu = opa & opb;
      OP_OR:   alu = opa | opb;
      OP_XOR:  alu = opa ^ opb;
      OP_SLL:  alu = opa << opb[4:0];
      OP_SRL:  alu = opa >> opb[4:0];
      default: alu = '0;
    endcase
  end

`ifdef REGFILE_EXEC_MUL_EN
  // opa is the shifting multiplicand, opb the shifting multiplier
  assign mul_sum = acc + (opb[0] ? opa : '0);
`endif

  // Outputs are registered: each is set on the edge entering its state.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      state   <= IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      opa     <= '0;
      opb     <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      read_a  <= 1'b0;
      a_addr  <= '0;
      read_b  <= 1'b0;
      b_addr  <= '0;
      write   <= 1'b0;
      in_addr <= '0;
      in      <= '0;
`ifdef REGFILE_EXEC_MUL_EN
      cnt     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            rd_q   <= rd;
            read_a <= 1'b1;
            a_addr <= rs1;
            read_b <= 1'b1;
            b_addr <= rs2;
            busy   <= 1'b1;
            state  <= READ;
          end
        end
        READ: begin
          read_a <= 1'b0;
          read_b <= 1'b0;
          a_addr <= '0;
          b_addr <= '0;
          opa    <= a;
          opb    <= b;
          if (op_q == OP_MUL) begin
`ifdef REGFILE_EXEC_MUL_EN
            acc   <= '0;
            cnt   <= '0;
            state <= MUL;
`else
            done  <= 1'b1;
            state <= EXEC;
`endif
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          if (op_q == OP_MUL) begin
            // Multiply not built: completion already flagged, nothing to write
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc     <= alu;
            write   <= 1'b1;
            in_addr <= rd_q;
            in      <= alu;
            done    <= 1'b1;
            state   <= WB;
          end
        end
`ifdef REGFILE_EXEC_MUL_EN
        MUL: begin
          acc <= mul_sum;
          opa <= opa << 1;
          opb <= opb >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == MUL_LAST) begin
            write   <= 1'b1;
            in_addr <= rd_q;
            in      <= mul_sum;
            done    <= 1'b1;
            state   <= WB;
          end
        end
`endif
        WB: begin
          write   <= 1'b0;
          in_addr <= '0;
          in      <= '0;
          result  <= acc;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
